// File: rtl/igbt_scr_pkg.sv
// Shared types and sizing for the IGBT/SCR pulse-train sequencer.
// Pure declarations; no latency or flow-control implications.
package igbt_scr_pkg;

    localparam int N_IGBT = 5;
    localparam int N_SCR  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ON    = 3'd1,
        ST_DEAD1 = 3'd2,
        ST_SCR   = 3'd3,
        ST_DEAD2 = 3'd4,
        ST_GAP   = 3'd5,
        ST_FAULT = 3'd6
    } seq_state_e;

    typedef struct packed {
        logic [N_IGBT-1:0] igbt_mask;
        logic [N_SCR-1:0]  scr_sel;
        logic [15:0]       on_us;
        logic [7:0]        dead_us;
        logic [15:0]       scr_us;
        logic [15:0]       gap_us;
        logic [7:0]        pulse_cnt;
    } seq_cfg_t;

    function automatic logic [15:0] eff_dead_us(input logic [7:0] dead_us, input int min_us);
        if (int'(dead_us) < min_us) begin
            return 16'(min_us);
        end
        return {8'd0, dead_us};
    endfunction

endpackage

// File: rtl/igbt_scr_sequencer_phase_timer.sv
// Microsecond-resolution phase down-timer; expire_o is combinational and flags the last cycle
// of a D-us phase (D*TICK_DIV cycles, or 1 cycle when D is 0). No backpressure.
module phase_timer #(
    parameter int TICK_DIV = 50
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        count_i,
    input  logic [15:0] dur_i,
    output logic        expire_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cyc_q;
    logic [15:0]   us_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_q <= '0;
            us_q  <= '0;
        end else if (load_i) begin
            cyc_q <= '0;
            us_q  <= dur_i;
        end else if (count_i && us_q != 16'd0) begin
            if (cyc_q == CYC_LAST) begin
                cyc_q <= '0;
                us_q  <= us_q - 16'd1;
            end else begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    assign expire_o = (us_q == 16'd0) || (us_q == 16'd1 && cyc_q == CYC_LAST);

endmodule

// File: rtl/igbt_scr_sequencer.sv
// Interlocked IGBT-on / dead / SCR-fire / dead / gap pulse-train sequencer with driver feedback check.
// All outputs registered, 1 cycle after the deciding input; no backpressure (start while busy is dropped).
module igbt_scr_sequencer
    import igbt_scr_pkg::*;
#(
    parameter int TICK_DIV    = 50,
    parameter int FB_TIMEOUT  = 4,
    parameter int MIN_DEAD_US = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              abort,
    input  logic              fault_clr,
    input  logic [N_IGBT-1:0] cfg_igbt_mask,
    input  logic [N_SCR-1:0]  cfg_scr_sel,
    input  logic [15:0]       cfg_on_us,
    input  logic [7:0]        cfg_dead_us,
    input  logic [15:0]       cfg_scr_us,
    input  logic [15:0]       cfg_gap_us,
    input  logic [7:0]        cfg_pulse_cnt,
    input  logic [N_IGBT-1:0] igbt_status,
    input  logic [N_SCR-1:0]  scr_status,
    output logic [N_IGBT-1:0] igbt_on_en,
    output logic [N_SCR-1:0]  scr_on_en,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output logic              cfg_err,
    output logic [7:0]        pulse_idx
);

    localparam int FBW = $clog2(FB_TIMEOUT + 1);
    localparam logic [FBW-1:0] FB_LAST = FBW'(FB_TIMEOUT - 1);

    seq_state_e state_q, state_d;
    seq_cfg_t   cfg_q, cfg_d;
    logic [7:0] pulse_idx_q, pulse_idx_d;
    logic       done_d, cfg_err_d;

    logic [N_IGBT-1:0] igbt_on_en_q;
    logic [N_SCR-1:0]  scr_on_en_q;
    logic              busy_q, done_q, fault_q, cfg_err_q;

    logic [N_IGBT-1:0][FBW-1:0] igbt_fb_q, igbt_fb_d;
    logic [N_SCR-1:0][FBW-1:0]  scr_fb_q, scr_fb_d;
    logic                       fb_fault;

    logic        tmr_load, tmr_count, tmr_expire;
    logic [15:0] tmr_dur;

    // Per-bit disagreement counters compare feedback against what is being driven this cycle.
    always_comb begin
        fb_fault  = 1'b0;
        igbt_fb_d = '0;
        scr_fb_d  = '0;
        if (state_q != ST_FAULT) begin
            for (int i = 0; i < N_IGBT; i++) begin
                if (igbt_status[i] != igbt_on_en_q[i]) begin
                    igbt_fb_d[i] = igbt_fb_q[i] + 1'b1;
                    if (igbt_fb_q[i] == FB_LAST) fb_fault = 1'b1;
                end
            end
            for (int i = 0; i < N_SCR; i++) begin
                if (scr_status[i] != scr_on_en_q[i]) begin
                    scr_fb_d[i] = scr_fb_q[i] + 1'b1;
                    if (scr_fb_q[i] == FB_LAST) fb_fault = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        pulse_idx_d = pulse_idx_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        if (fb_fault) begin
            state_d = ST_FAULT;
        end else if (abort && state_q != ST_FAULT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_on_us == 16'd0 || cfg_pulse_cnt == 8'd0) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            cfg_d = '{igbt_mask: cfg_igbt_mask, scr_sel: cfg_scr_sel,
                                      on_us: cfg_on_us, dead_us: cfg_dead_us,
                                      scr_us: cfg_scr_us, gap_us: cfg_gap_us,
                                      pulse_cnt: cfg_pulse_cnt};
                            pulse_idx_d = '0;
                            state_d     = ST_ON;
                        end
                    end
                end
                ST_ON:    if (tmr_expire) state_d = ST_DEAD1;
                ST_DEAD1: if (tmr_expire) state_d = (cfg_q.scr_us != 16'd0) ? ST_SCR : ST_GAP;
                ST_SCR:   if (tmr_expire) state_d = ST_DEAD2;
                ST_DEAD2: if (tmr_expire) state_d = ST_GAP;
                ST_GAP: begin
                    if (tmr_expire) begin
                        if (pulse_idx_q == cfg_q.pulse_cnt - 8'd1) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = ST_ON;
                            pulse_idx_d = pulse_idx_q + 8'd1;
                        end
                    end
                end
                ST_FAULT: if (fault_clr) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The timer is reloaded on every state change with the duration of the state being entered.
    always_comb begin
        tmr_dur = '0;
        case (state_d)
            ST_ON:              tmr_dur = cfg_d.on_us;
            ST_DEAD1, ST_DEAD2: tmr_dur = eff_dead_us(cfg_d.dead_us, MIN_DEAD_US);
            ST_SCR:             tmr_dur = cfg_d.scr_us;
            ST_GAP:             tmr_dur = cfg_d.gap_us;
            default:            tmr_dur = '0;
        endcase
    end

    assign tmr_load  = (state_d != state_q);
    assign tmr_count = (state_q != ST_IDLE) && (state_q != ST_FAULT);

    phase_timer #(.TICK_DIV(TICK_DIV)) u_phase_timer (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .load_i  (tmr_load),
        .count_i (tmr_count),
        .dur_i   (tmr_dur),
        .expire_o(tmr_expire)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            cfg_q        <= '0;
            pulse_idx_q  <= '0;
            igbt_on_en_q <= '0;
            scr_on_en_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            cfg_err_q    <= 1'b0;
            igbt_fb_q    <= '0;
            scr_fb_q     <= '0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            pulse_idx_q  <= pulse_idx_d;
            igbt_on_en_q <= (state_d == ST_ON)  ? cfg_d.igbt_mask : '0;
            scr_on_en_q  <= (state_d == ST_SCR) ? cfg_d.scr_sel   : '0;
            busy_q       <= (state_d != ST_IDLE) && (state_d != ST_FAULT);
            done_q       <= done_d;
            fault_q      <= (state_d == ST_FAULT);
            cfg_err_q    <= cfg_err_d;
            igbt_fb_q    <= igbt_fb_d;
            scr_fb_q     <= scr_fb_d;
        end
    end

    assign igbt_on_en = igbt_on_en_q;
    assign scr_on_en  = scr_on_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign cfg_err    = cfg_err_q;
    assign pulse_idx  = pulse_idx_q;

endmodule

// File: doc/igbt_scr_sequencer.md
Name: igbt_scr_sequencer

Overview:
- Pulse-train sequencer that drives the enable inputs of the IGBT/SCR driver stage (igbt_on_en[4:0], scr_on_en[1:0]) on the mainboard.
- On a start request it runs N pulses: IGBT group on → dead time → SCR fire → gap.
- Guarantees IGBT/SCR interlock and exact µs timing, and checks driver status feedback, shutting everything off on mismatch.

Parameters:
- TICK_DIV, 50, sys_clk cycles per µs (50 MHz clock).
- FB_TIMEOUT, 4, cycles a status bit may disagree with its commanded enable before fault.
- MIN_DEAD_US, 1, minimum dead time enforced in µs.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle request to begin a pulse train
- abort  in  1  stop immediately, return to idle
- fault_clr  in  1  clear sticky fault
- cfg_igbt_mask  in  5  IGBTs switched during the ON phase
- cfg_scr_sel  in  2  SCRs fired during the SCR phase
- cfg_on_us  in  16  IGBT on time, µs
- cfg_dead_us  in  8  dead time, µs; applied after IGBT-off and after SCR-off
- cfg_scr_us  in  16  SCR gate time, µs; 0 skips the SCR phase
- cfg_gap_us  in  16  inter-pulse gap, µs
- cfg_pulse_cnt  in  8  number of pulses
- igbt_status  in  5  IGBT status feedback from the driver
- scr_status  in  2  SCR status feedback from the driver
- igbt_on_en  out  5  IGBT enables to the driver
- scr_on_en  out  2  SCR enables to the driver
- busy  out  1  high in any state except IDLE and FAULT
- done  out  1  one-cycle pulse at normal train completion
- fault  out  1  sticky fault flag
- cfg_err  out  1  one-cycle pulse when a start is rejected
- pulse_idx  out  8  current pulse number, 0-based

Behaviour:
- Reset: all outputs 0, state IDLE, timers 0.
- All outputs are registered.
- States: IDLE, ON, DEAD1, SCR, DEAD2, GAP, FAULT.
- IDLE + start:
  - If cfg_on_us==0 or cfg_pulse_cnt==0, stay IDLE and pulse cfg_err the next cycle.
  - Otherwise latch all cfg_* inputs; config changes during a train have no effect.
  - Enter ON; igbt_on_en = mask and busy = 1 on the cycle after start is sampled.
- Phase timer:
  - Cycle counter runs 0..TICK_DIV-1, plus a µs counter; both clear on every state entry.
  - A phase of D µs lasts exactly D*TICK_DIV cycles.
- Effective dead time = max(cfg_dead_us, MIN_DEAD_US).
- Transitions:
  - ON → DEAD1 after on_us.
  - DEAD1 → SCR after dead time if scr_us≠0, otherwise → GAP.
  - SCR → DEAD2 after scr_us.
  - DEAD2 → GAP after dead time.
  - GAP → ON with pulse_idx+1 after gap_us, or → IDLE with a done pulse when pulse_idx == pulse_cnt-1.
  - gap_us==0 means GAP lasts 1 cycle.
- Output map:
  - igbt_on_en = mask only in ON.
  - scr_on_en = sel only in SCR.
  - 0 in every other state.
  - igbt_on_en and scr_on_en are never both nonzero in the same cycle.
- pulse_idx clears on start and holds its last value in IDLE.
- Feedback check runs in every state except FAULT.
  - Any bit where status ≠ commanded enable for FB_TIMEOUT consecutive cycles → FAULT.
  - Each bit has its own counter; the counter clears whenever the bit agrees.
- FAULT:
  - All enables 0 the next cycle; fault=1, busy=0.
  - Start is ignored and produces no cfg_err.
  - fault_clr → IDLE, fault=0.
- abort (any non-FAULT state): next cycle enables 0, state IDLE, no done pulse.
- Priority: sys_rst > fault detect > abort > start.
- start while busy is ignored.
- Simultaneous start and abort in IDLE: abort wins.
- Reset mid-train: enables drop on the next edge.

Decomposition:
- Package igbt_scr_pkg:
  - state enum.
  - N_IGBT=5, N_SCR=2.
  - Config struct bundling all cfg_* fields.
- Sub-module phase_timer: µs-resolution down-timer with load, count and expire outputs, parameterised by TICK_DIV.

Test Plan (TICK_DIV=50, FB_TIMEOUT=4, driver model echoes enables with 1-cycle delay):
1. Basic train.
   - Stimulus: mask=5'b00011, sel=2'b01, on=3, dead=2, scr=1, gap=5, cnt=2.
   - Response: igbt_on_en=00011 for 150 cycles, 0 for 100, scr_on_en=01 for 50, 0 for 100 + 250, then repeat.
   - done pulses once, 1300 cycles after the first enable; pulse_idx 0→1.
2. Edge configs.
   - dead=0 → 50-cycle dead time.
   - scr=0 → no scr_on_en activity, DEAD1 goes straight to GAP.
   - on=0 or cnt=0 → single cfg_err pulse, busy stays 0.
3. Abort in SCR phase: scr_on_en=0 and busy=0 on the next cycle, no done pulse; a fresh start then runs normally.
4. Feedback fault: force igbt_status[1]=0 during ON → fault=1 and all enables 0 exactly 4 cycles after the mismatch starts; start is ignored; fault_clr returns to IDLE.
5. Collisions:
   - start+abort in the same cycle → stays IDLE.
   - start while busy → ignored.
   - Config changes mid-train → timing unchanged.
   - sys_rst mid-ON → enables 0 next cycle.
6. Interlock assertion throughout all tests: never both igbt_on_en and scr_on_en nonzero in the same cycle.
